// File: rtl/decimal_divider.sv
// Multi-cycle decimal floating-point divider: (-1)^s * mant * 10^exp, A / B.
// Scales the dividend by powers of ten so the truncated quotient uses as many
// mantissa bits as possible, then runs a restoring shift-subtract division.
module decimal_divider #(
  parameter int unsigned MANT_W = 34,
  parameter int unsigned EXP_W  = 7,
  parameter int unsigned NUM_W  = 72
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              eval,
  output logic              done,
  input  logic              signA,
  input  logic [MANT_W-1:0] mantA,
  input  logic [EXP_W-1:0]  expA,
  input  logic              signB,
  input  logic [MANT_W-1:0] mantB,
  input  logic [EXP_W-1:0]  expB,
  output logic              signRes,
  output logic [MANT_W-1:0] mantRes,
  output logic [EXP_W-1:0]  expRes,
  output logic              divByZero
);

  localparam int unsigned CNT_W = $clog2(MANT_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SCALE, S_DIVIDE, S_FINAL, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                eval_prev;
  logic                do_eval;

  logic                sign_a, sign_a_nxt, sign_b, sign_b_nxt;
  logic [MANT_W-1:0]   mant_a, mant_a_nxt, mant_b, mant_b_nxt;
  logic [EXP_W-1:0]    exp_a, exp_a_nxt, exp_b, exp_b_nxt;

  logic                sign_q, sign_nxt;
  logic [EXP_W-1:0]    exp_q, exp_nxt;
  logic [NUM_W-1:0]    num_q, num_nxt;
  logic [MANT_W-1:0]   quo_q, quo_nxt;
  logic [CNT_W-1:0]    bit_idx, bit_idx_nxt;

  logic                done_nxt, sign_res_nxt, dbz_nxt;
  logic [MANT_W-1:0]   mant_res_nxt;
  logic [EXP_W-1:0]    exp_res_nxt;

  logic [NUM_W-1:0]    num_x10;
  logic [NUM_W-1:0]    div_shifted;
  logic [NUM_W-1:0]    trial;
  logic                trial_ge;

  // Rising-edge detect on eval: a held request starts only one operation.
  assign do_eval     = eval & ~eval_prev;
  assign num_x10     = (num_q << 3) + (num_q << 1);
  assign div_shifted = NUM_W'(mant_b) << MANT_W;
  assign trial       = NUM_W'(mant_b) << bit_idx;
  assign trial_ge    = (num_q >= trial);

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      eval_prev <= 1'b0;
      sign_a    <= 1'b0;
      mant_a    <= '0;
      exp_a     <= '0;
      sign_b    <= 1'b0;
      mant_b    <= '0;
      exp_b     <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      num_q     <= '0;
      quo_q     <= '0;
      bit_idx   <= '0;
      done      <= 1'b0;
      signRes   <= 1'b0;
      mantRes   <= '0;
      expRes    <= '0;
      divByZero <= 1'b0;
    end else begin
      state     <= state_nxt;
      eval_prev <= eval;
      sign_a    <= sign_a_nxt;
      mant_a    <= mant_a_nxt;
      exp_a     <= exp_a_nxt;
      sign_b    <= sign_b_nxt;
      mant_b    <= mant_b_nxt;
      exp_b     <= exp_b_nxt;
      sign_q    <= sign_nxt;
      exp_q     <= exp_nxt;
      num_q     <= num_nxt;
      quo_q     <= quo_nxt;
      bit_idx   <= bit_idx_nxt;
      done      <= done_nxt;
      signRes   <= sign_res_nxt;
      mantRes   <= mant_res_nxt;
      expRes    <= exp_res_nxt;
      divByZero <= dbz_nxt;
    end
  end

  // Next-state and datapath update for each phase of the division.
  always_comb begin
    state_nxt    = state;
    sign_a_nxt   = sign_a;
    mant_a_nxt   = mant_a;
    exp_a_nxt    = exp_a;
    sign_b_nxt   = sign_b;
    mant_b_nxt   = mant_b;
    exp_b_nxt    = exp_b;
    sign_nxt     = sign_q;
    exp_nxt      = exp_q;
    num_nxt      = num_q;
    quo_nxt      = quo_q;
    bit_idx_nxt  = bit_idx;
    done_nxt     = 1'b0;
    sign_res_nxt = signRes;
    mant_res_nxt = mantRes;
    exp_res_nxt  = expRes;
    dbz_nxt      = divByZero;

    unique case (state)
      S_IDLE: begin
        if (do_eval) begin
          sign_a_nxt = signA;
          mant_a_nxt = mantA;
          exp_a_nxt  = expA;
          sign_b_nxt = signB;
          mant_b_nxt = mantB;
          exp_b_nxt  = expB;
          state_nxt  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mant_b == '0 || mant_a == '0) begin
          sign_res_nxt = 1'b0;
          mant_res_nxt = '0;
          exp_res_nxt  = '0;
          dbz_nxt      = (mant_b == '0);
          state_nxt    = S_DONE;
        end else begin
          sign_nxt  = sign_a ^ sign_b;
          exp_nxt   = exp_a - exp_b;
          num_nxt   = NUM_W'(mant_a);
          state_nxt = S_SCALE;
        end
      end
      S_SCALE: begin
        // Multiply by ten while the quotient would still fit in MANT_W bits.
        if (num_x10 < div_shifted) begin
          num_nxt = num_x10;
          exp_nxt = exp_q - EXP_W'(1);
        end else begin
          quo_nxt     = '0;
          bit_idx_nxt = CNT_W'(MANT_W - 1);
          state_nxt   = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (trial_ge) begin
          num_nxt = num_q - trial;
        end
        quo_nxt = {quo_q[MANT_W-2:0], trial_ge};
        if (bit_idx == '0) begin
          state_nxt = S_FINAL;
        end else begin
          bit_idx_nxt = bit_idx - CNT_W'(1);
        end
      end
      S_FINAL: begin
        sign_res_nxt = sign_q;
        mant_res_nxt = quo_q;
        exp_res_nxt  = exp_q;
        dbz_nxt      = 1'b0;
        state_nxt    = S_DONE;
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_decimal_divider.sv
// Scoreboard bench for decimal_divider: expectations from a reference model
// are queued at each start and compared when done pulses.
module tb_decimal_divider;

  localparam int unsigned MANT_W = 34;
  localparam int unsigned EXP_W  = 7;

  typedef struct {
    logic              sign;
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic              dbz;
    int                edge_at;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              eval  = 1'b0;
  logic              done;
  logic              signA = 1'b0, signB = 1'b0;
  logic [MANT_W-1:0] mantA = '0, mantB = '0;
  logic [EXP_W-1:0]  expA = '0, expB = '0;
  logic              signRes, divByZero;
  logic [MANT_W-1:0] mantRes;
  logic [EXP_W-1:0]  expRes;

  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  exp_t last;

  decimal_divider dut (
    .clock(clock), .reset(reset), .eval(eval), .done(done),
    .signA(signA), .mantA(mantA), .expA(expA),
    .signB(signB), .mantB(mantB), .expB(expB),
    .signRes(signRes), .mantRes(mantRes), .expRes(expRes),
    .divByZero(divByZero)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference model: decimal scale by search, quotient by integer division.
  function automatic exp_t model(input logic sa, input logic [MANT_W-1:0] ma,
                                 input logic [EXP_W-1:0] ea, input logic sb_,
                                 input logic [MANT_W-1:0] mb, input logic [EXP_W-1:0] eb,
                                 input int start_edge);
    exp_t r;
    logic [127:0] num, lim;
    int k;
    r.sign = 1'b0; r.mant = '0; r.exp = '0; r.dbz = (mb == '0);
    r.edge_at = start_edge + 2;
    if (mb != '0 && ma != '0) begin
      num = 128'(ma);
      lim = 128'(mb) << MANT_W;
      k = 0;
      while (num * 10 < lim && k < 30) begin
        num = num * 10;
        k++;
      end
      r.sign = sa ^ sb_;
      r.mant = MANT_W'(num / 128'(mb));
      r.exp = EXP_W'(int'($signed(ea)) - int'($signed(eb)) - k);
      r.edge_at = start_edge + 38 + k;
    end
    return r;
  endfunction

  // Output monitor: compare each done pulse against the oldest expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        check_eq("sign", 64'(signRes), 64'(e.sign));
        check_eq("mant", 64'(mantRes), 64'(e.mant));
        check_eq("exp", 64'(expRes), 64'(e.exp));
        check_eq("div_by_zero", 64'(divByZero), 64'(e.dbz));
        check_eq("latency_edge", 64'(edge_cnt), 64'(e.edge_at));
        last = e;
      end
    end
  end

  task automatic set_ops(input logic sa, input logic [MANT_W-1:0] ma, input logic [EXP_W-1:0] ea,
                         input logic sb_, input logic [MANT_W-1:0] mb, input logic [EXP_W-1:0] eb);
    signA = sa; mantA = ma; expA = ea;
    signB = sb_; mantB = mb; expB = eb;
  endtask

  task automatic wait_empty(input string tag);
    int i;
    for (i = 0; i < 300 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      check_eq({tag, "_timeout"}, 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(negedge clock);
  endtask

  // Pulse eval for one cycle from a falling edge, queueing the expectation.
  task automatic run_op(input string tag, input logic sa, input logic [MANT_W-1:0] ma,
                        input logic [EXP_W-1:0] ea, input logic sb_,
                        input logic [MANT_W-1:0] mb, input logic [EXP_W-1:0] eb);
    @(negedge clock);
    set_ops(sa, ma, ea, sb_, mb, eb);
    sb.push_back(model(sa, ma, ea, sb_, mb, eb, edge_cnt + 1));
    eval = 1'b1;
    @(negedge clock);
    eval = 1'b0;
    wait_empty(tag);
  endtask

  initial begin
    int d0;
    logic [63:0] r1, r2;
    repeat (3) @(negedge clock);
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_sign", 64'(signRes), 64'(0));
    check_eq("rst_mant", 64'(mantRes), 64'(0));
    check_eq("rst_exp", 64'(expRes), 64'(0));
    check_eq("rst_dbz", 64'(divByZero), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_op("one_third", 0, 34'd1, 7'd0, 0, 34'd3, 7'd0);
    check_eq("one_third_mant_const", 64'(mantRes), 64'd3333333333);
    check_eq("one_third_exp_const", 64'(expRes), 64'(7'h76));
    run_op("six_neg_two", 0, 34'd6, 7'd0, 1, 34'd2, 7'd0);
    check_eq("six_neg_two_mant_const", 64'(mantRes), 64'd3000000000);
    check_eq("six_neg_two_sign_const", 64'(signRes), 64'(1));
    run_op("max_one", 0, 34'h3_FFFF_FFFF, 7'd3, 0, 34'd1, 7'd5);
    check_eq("max_one_exp_const", 64'(expRes), 64'(7'h7E));
    run_op("zero_num", 1, 34'd0, 7'd4, 0, 34'd5, 7'd1);
    run_op("div_zero", 1, 34'd5, 7'd4, 0, 34'd0, 7'd1);
    check_eq("div_zero_flag_const", 64'(divByZero), 64'(1));
    run_op("after_dbz", 1, 34'd7, 7'd2, 1, 34'd7, 7'd2);
    run_op("exp_wrap", 0, 34'd1, 7'h44, 0, 34'd1, 7'd10);
    run_op("neg_exp_wrap", 1, 34'd999, 7'd60, 0, 34'd17179869183, 7'h40);

    // Hold: outputs keep the last result while idle.
    repeat (10) @(negedge clock);
    check_eq("hold_mant", 64'(mantRes), 64'(last.mant));
    check_eq("hold_exp", 64'(expRes), 64'(last.exp));

    for (int i = 0; i < 8; i++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      if (i % 2 == 1) r2 = r2 & 64'hFFFF;
      if (r2[MANT_W-1:0] == '0) r2 = 64'd1;
      run_op("random", r1[40], r1[MANT_W-1:0], 7'($urandom), r2[40], r2[MANT_W-1:0], 7'($urandom));
    end

    // eval held high for 100 cycles starts exactly one operation.
    d0 = done_cnt;
    @(negedge clock);
    set_ops(0, 34'd22, 7'd1, 0, 34'd7, 7'd0);
    sb.push_back(model(0, 34'd22, 7'd1, 0, 34'd7, 7'd0, edge_cnt + 1));
    eval = 1'b1;
    repeat (100) @(negedge clock);
    eval = 1'b0;
    wait_empty("held_eval");
    repeat (60) @(negedge clock);
    check_eq("held_eval_done_count", 64'(done_cnt - d0), 64'(1));

    // A second start while busy is ignored; the first result comes back.
    @(negedge clock);
    set_ops(0, 34'd5, 7'd0, 0, 34'd9, 7'd0);
    sb.push_back(model(0, 34'd5, 7'd0, 0, 34'd9, 7'd0, edge_cnt + 1));
    eval = 1'b1;
    @(negedge clock);
    eval = 1'b0;
    repeat (5) @(negedge clock);
    set_ops(1, 34'd123, 7'd9, 1, 34'd0, 7'd2);
    eval = 1'b1;
    @(negedge clock);
    eval = 1'b0;
    wait_empty("busy_eval");
    repeat (60) @(negedge clock);
    check_eq("busy_eval_queue", 64'(sb.size()), 64'(0));

    // Reset mid-DIVIDE aborts with no done and clears the outputs.
    @(negedge clock);
    set_ops(0, 34'd1, 7'd0, 0, 34'd3, 7'd0);
    eval = 1'b1;
    @(negedge clock);
    eval = 1'b0;
    repeat (20) @(negedge clock);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check_eq("abort_mant", 64'(mantRes), 64'(0));
    check_eq("abort_exp", 64'(expRes), 64'(0));
    check_eq("abort_done", 64'(done), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'(0));
    check_eq("abort_mant_idle", 64'(mantRes), 64'(0));
    run_op("after_reset", 0, 34'd1, 7'd0, 0, 34'd3, 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
